// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register block.
// Holds the default payload width and the occupancy count type.
// No ports; imported by the interface, the entry flop and the top.
package pipe_pkg;

  // Default payload width for the skid register and its interface.
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Held-beat count, 0..2.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream interface carrying one WIDTH-bit payload per beat.
// Ports (via modports): master drives valid/data and samples ready;
// slave samples valid/data and drives ready.
interface pipe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_skid_reg_flopenrc.sv
// WIDTH-bit data register with enable and synchronous clear to RESET_VALUE.
// Ports: clk, rst (async active-low), en (load d), clr (sync clear, wins
// over en), d (next value), q (registered value).
module flopenrc
  import pipe_pkg::*;
#(
  parameter int unsigned     WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VALUE;
    end else if (clr) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full-throughput valid/ready pipeline stage with
// all outputs (in_ready, out_valid, out_data, occupancy) taken from flops.
// Ports: clk, rst (async active-low), flush (sync discard of held beats),
// in_if (upstream, slave), out_if (downstream, master), occupancy (0..2).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_skid_reg_if.slave        in_if,
  pipe_skid_reg_if.master       out_if,
  output occ_t                  occupancy
);

  // Entry state: main feeds the output, skid catches the beat that
  // arrives in the cycle the downstream stalls.
  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;

  // Next-state and enable controls.
  logic             in_xfer;
  logic             drain;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic             main_valid_d;
  logic             skid_valid_d;

  always_comb begin
    in_xfer      = in_if.valid && !skid_valid;
    drain        = !main_valid || out_if.ready;
    main_en      = 1'b0;
    skid_en      = 1'b0;
    main_d       = skid_data;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;

    if (drain) begin
      // Main is free this cycle: the older skid beat goes first,
      // otherwise the incoming beat passes straight into main.
      // A full skid forces in_ready low, so both cannot happen together.
      main_valid_d = skid_valid || in_xfer;
      main_en      = skid_valid || in_xfer;
      main_d       = skid_valid ? skid_data : in_if.data;
      skid_valid_d = 1'b0;
    end else if (in_xfer) begin
      // Main is stalled and skid is empty: park the new beat in skid.
      skid_en      = 1'b1;
      skid_valid_d = 1'b1;
    end

    // Flush overrides every transfer, including the offered input beat.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_en      = 1'b0;
      skid_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  flopenrc #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .clr (flush),
    .d   (main_d),
    .q   (main_data)
  );

  flopenrc #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (flush),
    .d   (in_if.data),
    .q   (skid_data)
  );

  // in_ready depends only on the skid flop, so there is no combinational
  // path from out_ready or in_valid back upstream.
  assign in_if.ready   = !skid_valid;
  assign out_if.valid  = main_valid;
  assign out_if.data   = main_data;
  assign occupancy     = occ_t'({1'b0, main_valid}) + occ_t'({1'b0, skid_valid});

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios plus random traffic, with
// a queue-based scoreboard and an independent monitor process.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int unsigned W  = 16;
  localparam logic [W-1:0] RV = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  occ_t occupancy;

  int checks = 0;
  int errors = 0;

  // Beats accepted by the block and not yet delivered, oldest first.
  logic [W-1:0] exp_q[$];

  pipe_skid_reg_if #(.WIDTH(W)) in_if ();
  pipe_skid_reg_if #(.WIDTH(W)) out_if ();

  pipe_skid_reg #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus. Inputs change on the falling edge; the model
  // is updated just after the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic rdy_before;
    logic acc;
    @(negedge clk);
    rdy_before    = in_if.ready;
    in_if.valid   = iv;
    in_if.data    = d;
    out_if.ready  = ordy;
    flush         = fl;
    #1;
    chk("in_ready_no_comb_path", 32'(in_if.ready), 32'(rdy_before));
    acc = iv && rdy_before;
    @(posedge clk);
    #1;
    if (!rst || fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
  endtask

  // Monitor: compares visible state to the model every cycle and retires
  // the head beat whenever the output handshake completes.
  initial begin
    int sz;
    forever begin
      @(negedge clk);
      #4;
      sz = exp_q.size();
      chk("occupancy", 32'(occupancy), 32'(sz));
      chk("out_valid", 32'(out_if.valid), 32'(sz != 0));
      chk("in_ready", 32'(in_if.ready), 32'(sz < 2));
      if (sz != 0) begin
        chk("out_data", 32'(out_if.data), 32'(exp_q[0]));
        if (out_if.valid && out_if.ready && !flush && rst) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] rd;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // Reset state.
    #1 rst = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_if.valid), 32'(0));
    chk("rst_in_ready", 32'(in_if.ready), 32'(1));
    chk("rst_occupancy", 32'(occupancy), 32'(0));
    chk("rst_out_data", 32'(out_if.data), 32'(RV));
    chk("rst_skid_data", 32'(dut.skid_data), 32'(RV));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming: one beat per cycle, each visible one cycle after input.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, W'(k), 1'b1, 1'b0);
      chk("stream_out_valid", 32'(out_if.valid), 32'(1));
      chk("stream_out_data", 32'(out_if.data), 32'(k));
      chk("stream_occ", 32'(occupancy), 32'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", 32'(out_if.valid), 32'(0));

    // Backpressure: two beats held, third refused until space frees.
    step(1'b1, 16'h000A, 1'b0, 1'b0);
    chk("bp_occ1", 32'(occupancy), 32'(1));
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_if.ready), 32'(0));
    chk("bp_occ2", 32'(occupancy), 32'(2));
    chk("bp_hold_a", 32'(out_if.data), 32'h000A);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    chk("bp_still_a", 32'(out_if.data), 32'h000A);
    chk("bp_still_full", 32'(occupancy), 32'(2));
    step(1'b1, 16'h000C, 1'b1, 1'b0);
    chk("bp_then_b", 32'(out_if.data), 32'h000B);
    step(1'b1, 16'h000C, 1'b1, 1'b0);
    chk("bp_then_c", 32'(out_if.data), 32'h000C);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", 32'(occupancy), 32'(0));

    // Flush while full, with a beat offered in the flush cycle.
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    chk("fl_full", 32'(occupancy), 32'(2));
    step(1'b1, 16'h000D, 1'b0, 1'b1);
    chk("fl_occ", 32'(occupancy), 32'(0));
    chk("fl_out_valid", 32'(out_if.valid), 32'(0));
    chk("fl_in_ready", 32'(in_if.ready), 32'(1));
    chk("fl_out_data", 32'(out_if.data), 32'(RV));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fl_no_d", 32'(out_if.valid), 32'(0));

    // Asynchronous reset in the middle of a cycle while full.
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    chk("ar_full", 32'(occupancy), 32'(2));
    @(negedge clk);
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_if.valid), 32'(0));
    chk("ar_out_data", 32'(out_if.data), 32'(RV));
    chk("ar_occ", 32'(occupancy), 32'(0));
    chk("ar_in_ready", 32'(in_if.ready), 32'(1));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 16'h0033, 1'b1, 1'b0);
    chk("ar_restart", 32'(out_if.data), 32'h0033);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      rd = W'($urandom);
      step(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end

    // Drain whatever is left.
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_empty", 32'(occupancy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter RESET_VALUE, default 0: payload value loaded into every data register on reset and on flush.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting (0) clears state immediately; deassertion is synchronised externally.
REQ-005 flush  input  1  synchronous clear; active-high; discards all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 occupancy  output  2  number of held beats, 0..2.

Function
REQ-013 Storage SHALL be two entries, each with a valid bit and WIDTH data: main (drives out_*) and skid.
REQ-014 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-015 in_ready SHALL equal !skid_valid, taken directly from a register; there is no combinational path from out_ready or in_valid to in_ready.
REQ-016 out_valid SHALL equal main_valid and out_data SHALL equal main_data, both straight from registers.
REQ-017 Main drains when !main_valid or out_ready; on a drain, main loads from skid if skid_valid, otherwise from the input beat if one transfers; otherwise main becomes invalid.
REQ-018 If main does not drain and an input transfer occurs, the beat SHALL be written to skid.
REQ-019 If main drains from skid and an input transfer occurs in the same cycle, this is impossible by REQ-015; skid empties.
REQ-020 Latency empty -> out_valid SHALL be exactly 1 cycle; sustained throughput with out_ready held high SHALL be 1 beat per cycle.
REQ-021 Beats SHALL leave in arrival order; no beat is duplicated or lost except by flush.
REQ-022 flush SHALL take priority over all transfers: next cycle main_valid = skid_valid = 0, data = RESET_VALUE, and in_ready = 1. An input beat offered during the flush cycle is discarded.
REQ-023 occupancy SHALL equal main_valid + skid_valid, registered-equivalent (no dependence on current-cycle inputs).
REQ-024 out_data SHALL hold stable while out_valid && !out_ready.
REQ-025 Data registers SHALL only load on an accepted write; a held entry is never overwritten.

Reset
REQ-026 While rst = 0: out_valid = 0, in_ready = 1, occupancy = 0, out_data = RESET_VALUE, skid data = RESET_VALUE.
REQ-027 Reset in mid-operation SHALL discard all held beats asynchronously; the first edge after release behaves as from empty.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the default WIDTH constant and the 2-bit occupancy type; no other constants.
REQ-029 Each entry SHALL be built from one sub-module, flopenrc: a WIDTH-parametrised flop with active-low asynchronous reset, enable, and synchronous clear to RESET_VALUE, instantiated twice.
REQ-030 Control SHALL be two valid flops plus combinational enable/select logic; no further FSM.

Verification
REQ-031 Streaming: out_ready = 1, 8 back-to-back beats 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, first one 1 cycle after the first input, occupancy never exceeds 1.
REQ-032 Backpressure: out_ready = 0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, in_ready = 0 from the cycle after 0xB, occupancy = 2, out_data stays 0xA; raise out_ready -> 0xA, 0xB, 0xC delivered in order.
REQ-033 Flush while full: occupancy = 2, flush = 1 with in_valid = 1 and data 0xD -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, and 0xD never appears.
REQ-034 Async reset: occupancy = 2, drop rst between clock edges -> out_valid = 0 and out_data = RESET_VALUE before the next edge.
REQ-035 Random: random in_valid and out_ready for 10k cycles against a scoreboard queue -> zero mismatches, zero losses, and in_ready never depends on same-cycle out_ready.
